// File: rtl/mult_accumulator_if.sv
// Product-in / sum-out handshake bundle for mult_accumulator.
// master = upstream/downstream environment, slave = the accumulator.
interface mult_accumulator_if #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic [15:0]      p;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [ACC_W-1:0] acc;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic [CNT_W-1:0] count;

    modport master (
        output p, in_valid, clear, out_ready,
        input  in_ready, acc, out_valid, ovf, count
    );

    modport slave (
        input  p, in_valid, clear, out_ready,
        output in_ready, acc, out_valid, ovf, count
    );
endinterface

// File: rtl/mult_accumulator.sv
// Sums LEN consecutive 16-bit products into an ACC_W-bit result with valid/ready on both sides.
// Optional build macro MULT_ACC_SATURATE_EN: clamp to all-ones on carry-out instead of wrapping.
module mult_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    mult_accumulator_if.slave   bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [SUM_W-1:0] sum;
    logic             accept;
    logic             last;

    assign accept = bus.in_valid && (state_q == ACCUM);
    assign last   = (count_q == CNT_W'(LEN - 1));
    // Extra MSB of sum is the carry out of the accumulator.
    assign sum    = {1'b0, acc_q} + SUM_W'(bus.p);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (bus.clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
`ifdef MULT_ACC_SATURATE_EN
                        acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        ovf_d = ovf_q | sum[ACC_W];
                        if (last) begin
                            count_d = '0;
                            state_d = HOLD;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: three configurations share one stimulus stream,
// checked by hand-written vectors and a running-total reference model.
module tb_mult_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic iv = 1'b0;
    logic [15:0] p = '0;
    logic ordy = 1'b0;

    always #5 clk = ~clk;

    mult_accumulator_if #(.LEN(4), .ACC_W(24)) if4();
    mult_accumulator_if #(.LEN(5), .ACC_W(18)) if5();
    mult_accumulator_if #(.LEN(1), .ACC_W(24)) if1();

    assign if4.p = p;  assign if4.in_valid = iv;  assign if4.clear = clr;  assign if4.out_ready = ordy;
    assign if5.p = p;  assign if5.in_valid = iv;  assign if5.clear = clr;  assign if5.out_ready = ordy;
    assign if1.p = p;  assign if1.in_valid = iv;  assign if1.clear = clr;  assign if1.out_ready = ordy;

    mult_accumulator #(.LEN(4), .ACC_W(24)) u4 (.clk(clk), .rst(rst), .bus(if4));
    mult_accumulator #(.LEN(5), .ACC_W(18)) u5 (.clk(clk), .rst(rst), .bus(if5));
    mult_accumulator #(.LEN(1), .ACC_W(24)) u1 (.clk(clk), .rst(rst), .bus(if1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: true running total of the current sum, mapped to ACC_W bits on read.
    int     lens [3] = '{4, 5, 1};
    int     ws   [3] = '{24, 18, 24};
    longint tot  [3];
    int     n    [3];
    bit     hold [3];

    function automatic longint exp_acc(input longint t, input int w);
        longint lim;
        lim = longint'(1) << w;
`ifdef MULT_ACC_SATURATE_EN
        return (t >= lim) ? lim - 1 : t;
`else
        return t % lim;
`endif
    endfunction

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (rst || clr) begin
                hold[d] = 1'b0; tot[d] = 0; n[d] = 0;
            end else if (hold[d]) begin
                if (ordy) begin
                    hold[d] = 1'b0; tot[d] = 0;
                end
            end else if (iv) begin
                tot[d] += longint'(p);
                n[d]++;
                if (n[d] == lens[d]) begin
                    n[d] = 0; hold[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_check();
        longint a; bit o, ir, ov; int c;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: begin a = longint'(if4.acc); o = if4.ovf; c = int'(if4.count); ir = if4.in_ready; ov = if4.out_valid; end
                1: begin a = longint'(if5.acc); o = if5.ovf; c = int'(if5.count); ir = if5.in_ready; ov = if5.out_valid; end
                default: begin a = longint'(if1.acc); o = if1.ovf; c = int'(if1.count); ir = if1.in_ready; ov = if1.out_valid; end
            endcase
            chk($sformatf("model[len%0d].acc", lens[d]), a, exp_acc(tot[d], ws[d]));
            chk($sformatf("model[len%0d].ovf", lens[d]), longint'(o), longint'(tot[d] >= (longint'(1) << ws[d])));
            chk($sformatf("model[len%0d].count", lens[d]), longint'(c), longint'(n[d]));
            chk($sformatf("model[len%0d].in_ready", lens[d]), longint'(ir), longint'(!hold[d]));
            chk($sformatf("model[len%0d].out_valid", lens[d]), longint'(ov), longint'(hold[d]));
        end
    endtask

    task automatic apply(input bit r, input bit c, input bit v, input int pv, input bit o);
        rst = r; clr = c; iv = v; p = 16'(pv); ordy = o;
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        bit     r, c, v;
        int     pv;
        bit     o;
        longint acc;
        bit     ovf;
        int     cnt;
        bit     ir, ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit c, bit v, int pv, bit o,
                                longint acc, bit ovf, int cnt, bit ir, bit ov);
        vec_t x;
        x.r = r; x.c = c; x.v = v; x.pv = pv; x.o = o;
        x.acc = acc; x.ovf = ovf; x.cnt = cnt; x.ir = ir; x.ov = ov;
        return x;
    endfunction

    initial begin
        // Expected LEN=4 / ACC_W=24 outputs after each edge.
        tbl.push_back(mk(1,0,0,0,0,       0,0,0,1,0));
        tbl.push_back(mk(0,0,1,100,0,     100,0,1,1,0));
        tbl.push_back(mk(0,0,1,200,0,     300,0,2,1,0));
        tbl.push_back(mk(0,0,1,300,0,     600,0,3,1,0));
        tbl.push_back(mk(0,0,1,400,0,     1000,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1,       0,0,0,1,0));
        tbl.push_back(mk(0,0,1,65025,0,   65025,0,1,1,0));
        tbl.push_back(mk(0,0,1,65025,0,   130050,0,2,1,0));
        tbl.push_back(mk(0,0,1,65025,0,   195075,0,3,1,0));
        tbl.push_back(mk(0,0,1,65025,0,   260100,0,0,0,1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,1,65025,0, 260100,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1,       0,0,0,1,0));
        tbl.push_back(mk(0,0,1,5,0,       5,0,1,1,0));
        tbl.push_back(mk(0,0,0,5,0,       5,0,1,1,0));
        tbl.push_back(mk(0,0,0,5,0,       5,0,1,1,0));
        tbl.push_back(mk(0,0,1,5,0,       10,0,2,1,0));
        tbl.push_back(mk(0,0,1,5,0,       15,0,3,1,0));
        tbl.push_back(mk(0,0,0,5,0,       15,0,3,1,0));
        tbl.push_back(mk(0,0,1,5,0,       20,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1,       0,0,0,1,0));
        tbl.push_back(mk(0,0,1,7,0,       7,0,1,1,0));
        tbl.push_back(mk(0,0,1,9,0,       16,0,2,1,0));
        tbl.push_back(mk(0,1,1,50,0,      0,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,0,       1,0,1,1,0));
        tbl.push_back(mk(0,0,1,2,0,       3,0,2,1,0));
        tbl.push_back(mk(0,0,1,3,0,       6,0,3,1,0));
        tbl.push_back(mk(0,0,1,4,0,       10,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,       10,0,0,0,1));
        tbl.push_back(mk(1,0,1,9,0,       0,0,0,1,0));
        tbl.push_back(mk(0,0,1,7,0,       7,0,1,1,0));
        tbl.push_back(mk(0,0,1,9,0,       16,0,2,1,0));
        tbl.push_back(mk(1,0,1,50,1,      0,0,0,1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].pv, tbl[i].o);
            chk($sformatf("tbl[%0d].acc", i), longint'(if4.acc), tbl[i].acc);
            chk($sformatf("tbl[%0d].ovf", i), longint'(if4.ovf), longint'(tbl[i].ovf));
            chk($sformatf("tbl[%0d].count", i), longint'(if4.count), longint'(tbl[i].cnt));
            chk($sformatf("tbl[%0d].in_ready", i), longint'(if4.in_ready), longint'(tbl[i].ir));
            chk($sformatf("tbl[%0d].out_valid", i), longint'(if4.out_valid), longint'(tbl[i].ov));
        end

        // LEN=1 hold/release and LEN=5 / ACC_W=18 overflow from one shared burst.
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 1, 65025, 0);
        chk("len1.out_valid", longint'(if1.out_valid), 1);
        chk("len1.acc", longint'(if1.acc), 65025);
        apply(0, 0, 1, 65025, 1);
        chk("len1.release_out_valid", longint'(if1.out_valid), 0);
        chk("len1.release_in_ready", longint'(if1.in_ready), 1);
        chk("len1.no_accept_acc", longint'(if1.acc), 0);
        apply(0, 0, 1, 65025, 0);
        apply(0, 0, 1, 65025, 0);
        apply(0, 0, 1, 65025, 0);
`ifdef MULT_ACC_SATURATE_EN
        chk("len5.ovf_acc", longint'(if5.acc), 262143);
`else
        chk("len5.ovf_acc", longint'(if5.acc), 62981);
`endif
        chk("len5.ovf", longint'(if5.ovf), 1);
        chk("len5.out_valid", longint'(if5.out_valid), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 65025 : int'($urandom_range(0, 65025)),
                  $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
